// File: rtl/button_event_reader_if.sv
// Event handshake bundle for the button reader.
// Producer drives valid/code, consumer drives ready.
interface button_event_reader_if;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;

  modport master (
    output evt_valid,
    output evt_code,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    output evt_ready
  );
endinterface

// File: rtl/button_event_reader.sv
// Push-button reader: sync, debounce, classify
// press / long / release into a 1-entry event buffer.
module button_event_reader #(
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int LONG_CYCLES     = 48000000
) (
  input  logic                          int_osc,
  input  logic                          rst,
  input  logic                          btn_n,
  output logic                          pressed,
  output logic                          evt_overflow,
  button_event_reader_if.master         evt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LMAX = LW'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_CHK,
    HELD,
    LONG_HELD,
    RELEASE_CHK
  } state_t;

  state_t        state, state_n;
  logic          sync1, btn_s;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic          long_flag, long_n;
  logic          pressed_n;
  logic          emit;
  logic [1:0]    emit_code;
  logic          valid;
  logic [1:0]    code;

  assign evt.evt_valid = valid;
  assign evt.evt_code  = code;

  // Two-flop synchroniser; btn_s is the inverted, active-high level.
  always_ff @(posedge int_osc) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= ~btn_n;
      btn_s <= sync1;
    end
  end

  // Debounce FSM state, counters and debounced level.
  always_ff @(posedge int_osc) begin
    if (rst) begin
      state     <= RELEASED;
      dcnt      <= '0;
      lcnt      <= '0;
      long_flag <= 1'b0;
      pressed   <= 1'b0;
    end else begin
      state     <= state_n;
      dcnt      <= dcnt_n;
      lcnt      <= lcnt_n;
      long_flag <= long_n;
      pressed   <= pressed_n;
    end
  end

  // Next-state, counter updates and event emission.
  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    lcnt_n    = lcnt;
    long_n    = long_flag;
    pressed_n = pressed;
    emit      = 1'b0;
    emit_code = 2'b00;
    unique case (state)
      RELEASED: begin
        if (btn_s) begin
          state_n = PRESS_CHK;
          dcnt_n  = '0;
        end
      end
      PRESS_CHK: begin
        if (!btn_s) begin
          state_n = RELEASED;
          long_n  = 1'b0;
        end else if (dcnt == DMAX) begin
          state_n   = HELD;
          pressed_n = 1'b1;
          lcnt_n    = '0;
          emit      = 1'b1;
          emit_code = 2'b01;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_n = RELEASE_CHK;
          dcnt_n  = '0;
        end else if (lcnt == LMAX) begin
          state_n   = LONG_HELD;
          long_n    = 1'b1;
          emit      = 1'b1;
          emit_code = 2'b10;
        end else begin
          lcnt_n = lcnt + LW'(1);
        end
      end
      LONG_HELD: begin
        if (!btn_s) begin
          state_n = RELEASE_CHK;
          dcnt_n  = '0;
        end
      end
      RELEASE_CHK: begin
        // lcnt is left untouched so a bounce resumes the hold timing.
        if (btn_s) begin
          state_n = long_flag ? LONG_HELD : HELD;
        end else if (dcnt == DMAX) begin
          state_n   = RELEASED;
          pressed_n = 1'b0;
          long_n    = 1'b0;
          emit      = 1'b1;
          emit_code = 2'b11;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      default: begin
        state_n = RELEASED;
      end
    endcase
  end

  // One-entry event buffer; a full unaccepted buffer drops new events.
  always_ff @(posedge int_osc) begin
    if (rst) begin
      valid        <= 1'b0;
      code         <= 2'b00;
      evt_overflow <= 1'b0;
    end else if (emit && (!valid || evt.evt_ready)) begin
      valid <= 1'b1;
      code  <= emit_code;
    end else if (emit) begin
      evt_overflow <= 1'b1;
    end else if (valid && evt.evt_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_event_reader.sv
// Directed bench for button_event_reader
// with DEBOUNCE_CYCLES=8, LONG_CYCLES=64.
module tb_button_event_reader;

  logic clk;
  logic rst;
  logic btn_n;
  logic pressed;
  logic evt_overflow;

  button_event_reader_if bus ();

  button_event_reader #(
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES(64)
  ) dut (
    .int_osc(clk),
    .rst(rst),
    .btn_n(btn_n),
    .pressed(pressed),
    .evt_overflow(evt_overflow),
    .evt(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int cyc;
  int rise_cyc;
  int t0;
  logic prev_pressed;
  int ev_code[$];
  int ev_cyc[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
      ev_code.push_back(int'(bus.evt_code));
      ev_cyc.push_back(cyc);
    end
    if (pressed === 1'b1 && prev_pressed !== 1'b1)
      rise_cyc = cyc;
    prev_pressed = pressed;
  endtask

  task automatic run(input int n, input logic b);
    btn_n = b;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    ev_code.delete();
    ev_cyc.delete();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    rise_cyc = -1;
    prev_pressed = 1'b0;
    rst = 1'b1;
    btn_n = 1'b1;
    bus.evt_ready = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) step();
    check("rst_pressed", pressed, 0);
    check("rst_valid", bus.evt_valid, 0);
    check("rst_code", bus.evt_code, 0);
    check("rst_ovf", evt_overflow, 0);
    rst = 1'b0;
    run(5, 1'b1);

    // clean press and release
    clr();
    t0 = cyc;
    run(20, 1'b0);
    check("press_n", ev_code.size(), 1);
    check("press_code", ev_code[0], 1);
    check("press_edge", ev_cyc[0] - t0, 11);
    check("press_lvl_edge", rise_cyc - t0, 11);
    check("press_pulse", bus.evt_valid, 0);
    check("code_hold", bus.evt_code, 1);
    check("pressed_hi", pressed, 1);
    clr();
    t0 = cyc;
    run(20, 1'b1);
    check("rel_n", ev_code.size(), 1);
    check("rel_code", ev_code[0], 3);
    check("rel_edge", ev_cyc[0] - t0, 11);
    check("rel_lvl", pressed, 0);

    // bounce on press, then a short release glitch
    clr();
    run(5, 1'b0);
    run(1, 1'b1);
    t0 = cyc;
    run(20, 1'b0);
    check("bnc_n", ev_code.size(), 1);
    check("bnc_code", ev_code[0], 1);
    check("bnc_edge", ev_cyc[0] - t0, 11);
    clr();
    run(3, 1'b1);
    run(20, 1'b0);
    check("glitch_n", ev_code.size(), 0);
    check("glitch_lvl", pressed, 1);
    run(20, 1'b1);
    clr();

    // long press
    t0 = cyc;
    run(100, 1'b0);
    run(20, 1'b1);
    check("long_n", ev_code.size(), 3);
    check("long_c0", ev_code[0], 1);
    check("long_e0", ev_cyc[0] - t0, 11);
    check("long_c1", ev_code[1], 2);
    check("long_e1", ev_cyc[1] - t0, 75);
    check("long_c2", ev_code[2], 3);
    check("long_e2", ev_cyc[2] - t0, 111);
    clr();

    // backpressure
    bus.evt_ready = 1'b0;
    run(20, 1'b0);
    run(20, 1'b1);
    check("bp_valid", bus.evt_valid, 1);
    check("bp_code", bus.evt_code, 1);
    check("bp_ovf", evt_overflow, 1);
    check("bp_lvl", pressed, 0);
    bus.evt_ready = 1'b1;
    step();
    check("bp_drain", bus.evt_valid, 0);
    run(10, 1'b1);
    check("bp_sticky", evt_overflow, 1);
    clr();

    // reset during PRESS_CHK with dcnt=5
    run(8, 1'b0);
    rst = 1'b1;
    step();
    check("mrst_lvl", pressed, 0);
    check("mrst_valid", bus.evt_valid, 0);
    check("mrst_code", bus.evt_code, 0);
    check("mrst_ovf", evt_overflow, 0);
    rst = 1'b0;
    clr();
    t0 = cyc;
    run(20, 1'b0);
    check("held_n", ev_code.size(), 1);
    check("held_edge", ev_cyc[0] - t0, 11);

    // reset during LONG_HELD
    run(70, 1'b0);
    check("lh_code", bus.evt_code, 2);
    rst = 1'b1;
    step();
    check("lrst_lvl", pressed, 0);
    check("lrst_valid", bus.evt_valid, 0);
    check("lrst_code", bus.evt_code, 0);
    rst = 1'b0;
    clr();
    run(20, 1'b1);
    check("lrst_quiet", ev_code.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
